id_ex_operand_stage: RTL and testbench

- Consumes the 4-bit Operand_A/B select codes from the forwarding unit and steers each operand from the register file or a later pipeline stage.
- Registers the selected operands plus rd into the ID/EX pipeline register.
- Owns the load-use interlock: inserts bubbles into EX and back-pressures IF/ID until load data can be forwarded.
- Sits between decode and the RV32IM execute stage.

---
 rtl/buraq_pipe_pkg.sv | 19 +
 rtl/id_ex_operand_stage_if.sv | 22 ++
 rtl/id_ex_operand_stage_operand_select_mux.sv | 36 +++
 rtl/id_ex_operand_stage.sv | 103 ++++++++++
 tb/tb_id_ex_operand_stage.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/buraq_pipe_pkg.sv
// Shared pipeline types: forwarding select codes and the load-use interlock states.
package buraq_pipe_pkg;

   typedef enum logic [3:0] {
      FWD_RF       = 4'b0000,
      FWD_WB       = 4'b0001,
      FWD_MEM_ALU  = 4'b0010,
      FWD_EX_LOAD  = 4'b0011,
      FWD_MEM_LOAD = 4'b0100,
      FWD_EX_ALU   = 4'b1000
   } fwd_sel_e;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      LOAD_BUBBLE = 2'd1,
      MEM_WAIT    = 2'd2
   } stall_state_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ID/EX output bundle. Handshake: an instruction moves into EX on a rising edge
// where ex_valid=1 and ex_ready=1; while ex_ready=0 the stage holds every field stable.
interface id_ex_operand_stage_if #(
   parameter int DataWidth    = 32,
   parameter int RegAddrWidth = 5
);
   logic                    ex_valid;
   logic                    ex_ready;
   logic [DataWidth-1:0]    ex_operand_a;
   logic [DataWidth-1:0]    ex_operand_b;
   logic [RegAddrWidth-1:0] ex_rd;

   modport master (
      output ex_valid, ex_operand_a, ex_operand_b, ex_rd,
      input  ex_ready
   );

   modport slave (
      input  ex_valid, ex_operand_a, ex_operand_b, ex_rd,
      output ex_ready
   );
endinterface

// File: rtl/id_ex_operand_stage_operand_select_mux.sv
// Six-way operand steering for one operand; undefined codes fall back to the
// register file value and raise illegal.
module operand_select_mux
   import buraq_pipe_pkg::*;
#(
   parameter int DataWidth = 32
) (
   input  logic [3:0]           sel,
   input  logic [DataWidth-1:0] rf_data,
   input  logic [DataWidth-1:0] wb_data,
   input  logic [DataWidth-1:0] mem_alu_result,
   input  logic [DataWidth-1:0] ex_alu_result,
   input  logic [DataWidth-1:0] mem_load_data,
   output logic [DataWidth-1:0] data,
   output logic                 illegal
);

   always_comb begin
      data    = rf_data;
      illegal = 1'b0;
      case (sel)
         FWD_RF:       data = rf_data;
         FWD_WB:       data = wb_data;
         FWD_MEM_ALU:  data = mem_alu_result;
         FWD_EX_ALU:   data = ex_alu_result;
         FWD_MEM_LOAD: data = mem_load_data;
         // Load still in EX: value is meaningless, the interlock keeps it out of EX.
         FWD_EX_LOAD:  data = rf_data;
         default: begin
            data    = rf_data;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: forwarding muxes, ID/EX register and the load-use interlock.
module id_ex_operand_stage
   import buraq_pipe_pkg::*;
#(
   parameter int DataWidth     = 32,
   parameter int RegAddrWidth  = 5,
   parameter int StallCntWidth = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     id_valid,
   output logic                     id_ready,
   input  logic [DataWidth-1:0]     id_rs1_data,
   input  logic [DataWidth-1:0]     id_rs2_data,
   input  logic [RegAddrWidth-1:0]  id_rd,
   input  logic [3:0]               operand_a_ctrl,
   input  logic [3:0]               operand_b_ctrl,
   input  logic [DataWidth-1:0]     ex_alu_result,
   input  logic [DataWidth-1:0]     mem_alu_result,
   input  logic [DataWidth-1:0]     mem_load_data,
   input  logic                     mem_load_valid,
   input  logic [DataWidth-1:0]     wb_data,
   input  logic                     flush,
   id_ex_operand_stage_if.master    ex,
   output logic [1:0]               stall_state,
   output logic [StallCntWidth-1:0] stall_cycles,
   output logic                     illegal_ctrl
);

   logic [DataWidth-1:0] sel_a, sel_b;
   logic                 illegal_a, illegal_b;
   logic                 any_ex_load, any_mem_wait, need_stall;
   stall_state_e         state, state_next;

   operand_select_mux #(.DataWidth(DataWidth)) u_mux_a (
      .sel(operand_a_ctrl), .rf_data(id_rs1_data), .wb_data(wb_data),
      .mem_alu_result(mem_alu_result), .ex_alu_result(ex_alu_result),
      .mem_load_data(mem_load_data), .data(sel_a), .illegal(illegal_a)
   );

   operand_select_mux #(.DataWidth(DataWidth)) u_mux_b (
      .sel(operand_b_ctrl), .rf_data(id_rs2_data), .wb_data(wb_data),
      .mem_alu_result(mem_alu_result), .ex_alu_result(ex_alu_result),
      .mem_load_data(mem_load_data), .data(sel_b), .illegal(illegal_b)
   );

   assign any_ex_load  = (operand_a_ctrl == FWD_EX_LOAD) || (operand_b_ctrl == FWD_EX_LOAD);
   assign any_mem_wait = ((operand_a_ctrl == FWD_MEM_LOAD) || (operand_b_ctrl == FWD_MEM_LOAD))
                         && !mem_load_valid;
   assign need_stall   = id_valid && (any_ex_load || any_mem_wait);
   assign id_ready     = flush || (ex.ex_ready && !need_stall);
   assign stall_state  = state;

   // The FSM only reports the interlock phase; need_stall alone gates advancement.
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = RUN;
      end else if (ex.ex_ready) begin
         case (state)
            RUN, LOAD_BUBBLE: begin
               if (any_ex_load)       state_next = LOAD_BUBBLE;
               else if (any_mem_wait) state_next = MEM_WAIT;
               else                   state_next = RUN;
            end
            MEM_WAIT: state_next = any_mem_wait ? MEM_WAIT : RUN;
            default:  state_next = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         ex.ex_valid     <= 1'b0;
         ex.ex_operand_a <= '0;
         ex.ex_operand_b <= '0;
         ex.ex_rd        <= '0;
         stall_cycles <= '0;
         illegal_ctrl <= 1'b0;
      end else begin
         state <= state_next;
         if (id_valid && (illegal_a || illegal_b)) illegal_ctrl <= 1'b1;
         if (flush) begin
            ex.ex_valid <= 1'b0;
         end else if (ex.ex_ready) begin
            if (need_stall) begin
               ex.ex_valid <= 1'b0;
               if (stall_cycles != '1)
                  stall_cycles <= stall_cycles + {{(StallCntWidth-1){1'b0}}, 1'b1};
            end else if (id_valid) begin
               ex.ex_valid     <= 1'b1;
               ex.ex_operand_a <= sel_a;
               ex.ex_operand_b <= sel_b;
               ex.ex_rd        <= id_rd;
            end else begin
               ex.ex_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: forwarding selects, load-use interlock,
// EX hold, flush priority, sticky illegal flag and asynchronous reset.
module tb_id_ex_operand_stage;
   import buraq_pipe_pkg::*;

   logic        clk, rst_n;
   logic        id_valid, id_ready;
   logic [31:0] id_rs1_data, id_rs2_data;
   logic [4:0]  id_rd;
   logic [3:0]  operand_a_ctrl, operand_b_ctrl;
   logic [31:0] ex_alu_result, mem_alu_result, mem_load_data, wb_data;
   logic        mem_load_valid, flush;
   logic [1:0]  stall_state;
   logic [15:0] stall_cycles;
   logic        illegal_ctrl;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_stall = '0;

   id_ex_operand_stage_if #(.DataWidth(32), .RegAddrWidth(5)) ex_bus ();

   id_ex_operand_stage #(.DataWidth(32), .RegAddrWidth(5), .StallCntWidth(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rd(id_rd),
      .operand_a_ctrl(operand_a_ctrl), .operand_b_ctrl(operand_b_ctrl),
      .ex_alu_result(ex_alu_result), .mem_alu_result(mem_alu_result),
      .mem_load_data(mem_load_data), .mem_load_valid(mem_load_valid),
      .wb_data(wb_data), .flush(flush), .ex(ex_bus.master),
      .stall_state(stall_state), .stall_cycles(stall_cycles), .illegal_ctrl(illegal_ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      id_valid = 1'b0; id_rs1_data = '0; id_rs2_data = '0; id_rd = '0;
      operand_a_ctrl = 4'b0000; operand_b_ctrl = 4'b0000;
      ex_alu_result = '0; mem_alu_result = '0; mem_load_data = '0;
      mem_load_valid = 1'b0; wb_data = '0; flush = 1'b0; ex_bus.ex_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      #2;
      checks++; if (ex_bus.ex_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h expected 0", ex_bus.ex_valid); end
      checks++; if (ex_bus.ex_operand_a !== 32'h0) begin errors++; $display("FAIL rst_op_a: got %h expected 0", ex_bus.ex_operand_a); end
      checks++; if (ex_bus.ex_operand_b !== 32'h0) begin errors++; $display("FAIL rst_op_b: got %h expected 0", ex_bus.ex_operand_b); end
      checks++; if (ex_bus.ex_rd !== 5'd0) begin errors++; $display("FAIL rst_rd: got %0d expected 0", ex_bus.ex_rd); end
      checks++; if (stall_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", stall_state); end
      checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_stall: got %0d expected 0", stall_cycles); end
      checks++; if (illegal_ctrl !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %0h expected 0", illegal_ctrl); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_plain_advance();
      id_valid = 1'b1; id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_rd = 5'd5;
      #1;
      checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL adv_id_ready: got %0h expected 1", id_ready); end
      tick();
      checks++; if (ex_bus.ex_valid !== 1'b1) begin errors++; $display("FAIL adv_valid: got %0h expected 1", ex_bus.ex_valid); end
      checks++; if (ex_bus.ex_operand_a !== 32'h11) begin errors++; $display("FAIL adv_op_a: got %h expected 11", ex_bus.ex_operand_a); end
      checks++; if (ex_bus.ex_operand_b !== 32'h22) begin errors++; $display("FAIL adv_op_b: got %h expected 22", ex_bus.ex_operand_b); end
      checks++; if (ex_bus.ex_rd !== 5'd5) begin errors++; $display("FAIL adv_rd: got %0d expected 5", ex_bus.ex_rd); end
   endtask

   task automatic test_forward_mix();
      operand_a_ctrl = 4'b1000; ex_alu_result = 32'hAAAA0001;
      operand_b_ctrl = 4'b0001; wb_data = 32'h5; id_rd = 5'd9;
      tick();
      checks++; if (ex_bus.ex_operand_a !== 32'hAAAA0001) begin errors++; $display("FAIL fwd_ex_alu: got %h expected aaaa0001", ex_bus.ex_operand_a); end
      checks++; if (ex_bus.ex_operand_b !== 32'h5) begin errors++; $display("FAIL fwd_wb: got %h expected 5", ex_bus.ex_operand_b); end
      checks++; if (ex_bus.ex_rd !== 5'd9) begin errors++; $display("FAIL fwd_rd: got %0d expected 9", ex_bus.ex_rd); end
      operand_a_ctrl = 4'b0010; mem_alu_result = 32'h1234;
      operand_b_ctrl = 4'b0100; mem_load_valid = 1'b1; mem_load_data = 32'h77;
      tick();
      checks++; if (ex_bus.ex_operand_a !== 32'h1234) begin errors++; $display("FAIL fwd_mem_alu: got %h expected 1234", ex_bus.ex_operand_a); end
      checks++; if (ex_bus.ex_operand_b !== 32'h77) begin errors++; $display("FAIL fwd_mem_load: got %h expected 77", ex_bus.ex_operand_b); end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL fwd_no_stall: got %0d expected %0d", stall_cycles, exp_stall); end
      drive_idle(); id_valid = 1'b1;
   endtask

   task automatic test_load_use();
      operand_a_ctrl = 4'b0011; id_rs1_data = 32'h1; id_rd = 5'd3;
      #1;
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_id_ready: got %0h expected 0", id_ready); end
      tick(); exp_stall = exp_stall + 16'd1;
      checks++; if (ex_bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %0h expected 0", ex_bus.ex_valid); end
      checks++; if (stall_state !== 2'd1) begin errors++; $display("FAIL lu_state: got %0d expected 1", stall_state); end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL lu_stall: got %0d expected %0d", stall_cycles, exp_stall); end
      operand_a_ctrl = 4'b0100; mem_load_valid = 1'b1; mem_load_data = 32'hDEAD;
      #1;
      checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_ready2: got %0h expected 1", id_ready); end
      tick();
      checks++; if (ex_bus.ex_valid !== 1'b1) begin errors++; $display("FAIL lu_valid2: got %0h expected 1", ex_bus.ex_valid); end
      checks++; if (ex_bus.ex_operand_a !== 32'hDEAD) begin errors++; $display("FAIL lu_op_a: got %h expected dead", ex_bus.ex_operand_a); end
      checks++; if (stall_state !== 2'd0) begin errors++; $display("FAIL lu_state2: got %0d expected 0", stall_state); end
      drive_idle(); id_valid = 1'b1;
   endtask

   task automatic test_slow_mem();
      operand_b_ctrl = 4'b0100; mem_load_valid = 1'b0; id_rd = 5'd12;
      for (int i = 0; i < 3; i++) begin
         tick(); exp_stall = exp_stall + 16'd1;
         checks++; if (ex_bus.ex_valid !== 1'b0) begin errors++; $display("FAIL slow_bubble%0d: got %0h expected 0", i, ex_bus.ex_valid); end
         checks++; if (stall_state !== 2'd2) begin errors++; $display("FAIL slow_state%0d: got %0d expected 2", i, stall_state); end
      end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL slow_stall: got %0d expected %0d", stall_cycles, exp_stall); end
      mem_load_valid = 1'b1; mem_load_data = 32'hBEEF;
      tick();
      checks++; if (ex_bus.ex_valid !== 1'b1) begin errors++; $display("FAIL slow_valid: got %0h expected 1", ex_bus.ex_valid); end
      checks++; if (ex_bus.ex_operand_b !== 32'hBEEF) begin errors++; $display("FAIL slow_op_b: got %h expected beef", ex_bus.ex_operand_b); end
      checks++; if (stall_state !== 2'd0) begin errors++; $display("FAIL slow_state_end: got %0d expected 0", stall_state); end
      drive_idle(); id_valid = 1'b1;
   endtask

   task automatic test_both_stall();
      operand_a_ctrl = 4'b0011; operand_b_ctrl = 4'b0100; mem_load_valid = 1'b0;
      id_rs1_data = 32'hA1; id_rd = 5'd20;
      tick(); exp_stall = exp_stall + 16'd1;
      checks++; if (stall_state !== 2'd1) begin errors++; $display("FAIL both_state1: got %0d expected 1", stall_state); end
      operand_a_ctrl = 4'b0000;
      tick(); exp_stall = exp_stall + 16'd1;
      checks++; if (stall_state !== 2'd2) begin errors++; $display("FAIL both_state2: got %0d expected 2", stall_state); end
      checks++; if (ex_bus.ex_valid !== 1'b0) begin errors++; $display("FAIL both_bubble: got %0h expected 0", ex_bus.ex_valid); end
      mem_load_valid = 1'b1; mem_load_data = 32'hC0DE;
      tick();
      checks++; if (ex_bus.ex_operand_a !== 32'hA1) begin errors++; $display("FAIL both_op_a: got %h expected a1", ex_bus.ex_operand_a); end
      checks++; if (ex_bus.ex_operand_b !== 32'hC0DE) begin errors++; $display("FAIL both_op_b: got %h expected c0de", ex_bus.ex_operand_b); end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL both_stall: got %0d expected %0d", stall_cycles, exp_stall); end
      drive_idle();
   endtask

   task automatic test_ex_hold();
      ex_bus.ex_ready = 1'b0; id_valid = 1'b1; operand_a_ctrl = 4'b0011; id_rs1_data = 32'h99; id_rd = 5'd1;
      #1;
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL hold_id_ready: got %0h expected 0", id_ready); end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (ex_bus.ex_valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d: got %0h expected 1", i, ex_bus.ex_valid); end
         checks++; if (ex_bus.ex_operand_a !== 32'hA1) begin errors++; $display("FAIL hold_op_a%0d: got %h expected a1", i, ex_bus.ex_operand_a); end
         checks++; if (ex_bus.ex_operand_b !== 32'hC0DE) begin errors++; $display("FAIL hold_op_b%0d: got %h expected c0de", i, ex_bus.ex_operand_b); end
         checks++; if (ex_bus.ex_rd !== 5'd20) begin errors++; $display("FAIL hold_rd%0d: got %0d expected 20", i, ex_bus.ex_rd); end
         checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL hold_stall%0d: got %0d expected %0d", i, stall_cycles, exp_stall); end
         checks++; if (stall_state !== 2'd0) begin errors++; $display("FAIL hold_state%0d: got %0d expected 0", i, stall_state); end
      end
      drive_idle();
      tick();
      checks++; if (ex_bus.ex_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %0h expected 0", ex_bus.ex_valid); end
   endtask

   task automatic test_flush();
      id_valid = 1'b1; operand_a_ctrl = 4'b0011;
      tick(); exp_stall = exp_stall + 16'd1;
      checks++; if (stall_state !== 2'd1) begin errors++; $display("FAIL fl_pre_state: got %0d expected 1", stall_state); end
      flush = 1'b1;
      #1;
      checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL fl_id_ready: got %0h expected 1", id_ready); end
      tick();
      checks++; if (ex_bus.ex_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %0h expected 0", ex_bus.ex_valid); end
      checks++; if (stall_state !== 2'd0) begin errors++; $display("FAIL fl_state: got %0d expected 0", stall_state); end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL fl_stall: got %0d expected %0d", stall_cycles, exp_stall); end
      drive_idle(); id_valid = 1'b1; id_rs1_data = 32'h55;
      tick();
      checks++; if (ex_bus.ex_valid !== 1'b1) begin errors++; $display("FAIL fl_refill: got %0h expected 1", ex_bus.ex_valid); end
      flush = 1'b1; ex_bus.ex_ready = 1'b0;
      tick();
      checks++; if (ex_bus.ex_valid !== 1'b0) begin errors++; $display("FAIL fl_over_hold: got %0h expected 0", ex_bus.ex_valid); end
      drive_idle();
   endtask

   task automatic test_illegal();
      id_valid = 1'b1; operand_a_ctrl = 4'b0111; id_rs1_data = 32'h3C; id_rd = 5'd7;
      tick();
      checks++; if (ex_bus.ex_operand_a !== 32'h3C) begin errors++; $display("FAIL ill_op_a: got %h expected 3c", ex_bus.ex_operand_a); end
      checks++; if (illegal_ctrl !== 1'b1) begin errors++; $display("FAIL ill_flag: got %0h expected 1", illegal_ctrl); end
      operand_a_ctrl = 4'b0000;
      tick();
      checks++; if (illegal_ctrl !== 1'b1) begin errors++; $display("FAIL ill_sticky: got %0h expected 1", illegal_ctrl); end
      drive_idle();
   endtask

   task automatic test_async_reset();
      id_valid = 1'b1; operand_b_ctrl = 4'b0100; mem_load_valid = 1'b0;
      tick(); exp_stall = exp_stall + 16'd1;
      checks++; if (stall_state !== 2'd2) begin errors++; $display("FAIL ar_pre_state: got %0d expected 2", stall_state); end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL ar_pre_stall: got %0d expected %0d", stall_cycles, exp_stall); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (stall_state !== 2'd0) begin errors++; $display("FAIL ar_state: got %0d expected 0", stall_state); end
      checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL ar_stall: got %0d expected 0", stall_cycles); end
      checks++; if (illegal_ctrl !== 1'b0) begin errors++; $display("FAIL ar_illegal: got %0h expected 0", illegal_ctrl); end
      checks++; if (ex_bus.ex_operand_a !== 32'h0) begin errors++; $display("FAIL ar_op_a: got %h expected 0", ex_bus.ex_operand_a); end
      checks++; if (ex_bus.ex_rd !== 5'd0) begin errors++; $display("FAIL ar_rd: got %0d expected 0", ex_bus.ex_rd); end
      exp_stall = '0;
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_plain_advance();
      test_forward_mix();
      test_load_use();
      test_slow_mem();
      test_both_stall();
      test_ex_hold();
      test_flush();
      test_illegal();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
